lsu_mem_ctrl: RTL
=================

Name: lsu_mem_ctrl

Overview:
Load/store unit that sits directly upstream of the word-wide data memory in the RV32I core. It accepts one load or store request at a time from the execute stage. Byte and halfword stores are turned into a single-cycle read-modify-write on the full-word memory port. Load data is sign- or zero-extended, and misaligned, illegal or out-of-range accesses are reported as an error instead of touching memory.

Parameters:
MEM_ADDR_W, 10, byte-address width of the memory port; bits [1:0] are always driven 0.
DATA_WIDTH, 32 (from pkg_config), data bus width. Only 32 is supported.

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
req_valid_i  in  1  request valid from execute stage
req_ready_o  out  1  request accepted when valid && ready
req_we_i  in  1  1 = store, 0 = load
req_funct3_i  in  3  RV32I funct3 of the load/store
req_addr_i  in  32  byte address
req_wdata_i  in  32  store data, right-aligned (byte/halfword in the low bits)
resp_valid_o  out  1  one-cycle completion pulse
resp_rdata_o  out  32  extended load data; 0 for stores and errors
resp_err_o  out  1  misaligned, illegal funct3 or out-of-range; valid with resp_valid_o
mem_we_o  out  1  memory write enable
mem_addr_o  out  MEM_ADDR_W  word-aligned byte address to memory
mem_wdata_o  out  32  full-word write data to memory
mem_rdata_i  in  32  combinational read data from memory at mem_addr_o

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Registered state, asynchronous reset to IDLE.
- Reset values:
  - req_ready_o = 1 (decoded from IDLE).
  - resp_valid_o, resp_err_o, mem_we_o = 0.
  - resp_rdata_o, mem_addr_o, mem_wdata_o = 0.
  - All latched request fields = 0.
- IDLE:
  - req_ready_o = 1.
  - On accept, latch we, funct3, addr and wdata.
  - Compute err = illegal funct3 || misaligned || out-of-range.
  - If err: go to RESP with resp_err_o = 1 and no memory access. Otherwise go to ACCESS.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal, e.g. load 011, store 1xx.
- Misaligned: halfword with addr[0] = 1; word with addr[1:0] != 0.
- Out-of-range: addr[31:MEM_ADDR_W] != 0.
- ACCESS (exactly one cycle):
  - mem_addr_o = {latched addr[MEM_ADDR_W-1:2], 2'b00}.
  - Load: select the lane from mem_rdata_i using addr[1:0].
    - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
    - Register the result into resp_rdata_o.
  - SW: mem_we_o = 1, mem_wdata_o = wdata.
  - SB/SH: merge in the same cycle.
    - mem_wdata_o = mem_rdata_i with the addressed byte lane (addr[1:0]) or halfword lane (addr[1]) replaced by wdata[7:0] or wdata[15:0].
    - mem_we_o = 1.
  - Go to RESP.
- mem_we_o:
  - Asserted only in ACCESS for stores; never in IDLE or RESP.
  - It is a pure decode of state plus the latched we bit, so it drops on the reset edge.
- RESP:
  - resp_valid_o = 1 for exactly one cycle.
  - resp_err_o and resp_rdata_o hold their registered values during this cycle.
  - Return to IDLE; req_ready_o is low here.
- Latency and throughput:
  - Legal request accepted at cycle T → write or read at T+1 → resp_valid_o at T+2.
  - Error request accepted at T → resp_valid_o at T+1.
  - Throughput is one request per 3 cycles (2 for errors).
  - No back-to-back accept: ready is low in ACCESS and RESP.
- Between responses:
  - resp_rdata_o and resp_err_o are cleared to 0 when leaving RESP.
  - mem_addr_o holds its last value.
- req_valid_i while not ready is ignored; the requester must hold the request stable until accepted.
- Reset mid-operation:
  - Immediate return to IDLE and the write is dropped.
  - No resp_valid_o is generated for the aborted request.

Decomposition:
- Add to pkg_config:
  - typedef enum lsu_state_e {IDLE, ACCESS, RESP}.
  - Funct3 localparams F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101.
- One combinational sub-module, lsu_align, holding:
  - Load lane select and extension.
  - Store byte-lane merge.
  - Misalignment and illegal-funct3 check.
- The FSM and registers stay in lsu_mem_ctrl.

Test Plan:
- Reset, then SW addr 0x10 data 0xDEADBEEF → at T+1 mem_we_o = 1, mem_addr_o = 0x10, mem_wdata_o = 0xDEADBEEF; at T+2 resp_valid_o = 1, resp_err_o = 0.
- Memory word 0x11223344, SB addr 0x12 data 0x000000AA → mem_wdata_o = 0x11AA3344; SH addr 0x12 data 0xBEEF → mem_wdata_o = 0xBEEF3344.
- Memory word 0x80FF7F01:
  - LB addr+3 → 0xFFFFFF80; LBU addr+3 → 0x00000080.
  - LH addr+2 → 0xFFFF80FF; LHU addr+2 → 0x000080FF.
  - LW → 0x80FF7F01.
- LW addr 0x06, SH addr 0x05, load funct3 011, addr 0x400 (MEM_ADDR_W = 10):
  - Each gives resp_err_o = 1 and resp_valid_o at T+1.
  - mem_we_o stays 0 and resp_rdata_o = 0.
- req_valid_i held high continuously with legal loads → req_ready_o pattern 1,0,0 repeating; exactly one resp_valid_o per accept.
- SW accepted, rst_n_i pulsed low during ACCESS → mem_we_o drops asynchronously, the memory word is unchanged, no resp_valid_o, req_ready_o = 1 after reset release.

Source files
------------

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 codes
// and the funct3 legality check.
package lsu_mem_ctrl_pkg;

   localparam int unsigned DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Stores have no unsigned variants, so only B/H/W are legal for them.
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      if (we) begin
         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      end
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Combinational datapath for the LSU: request legality/alignment checks, load lane
// select with extension, and byte/halfword store merge into the read word.
module lsu_align
   import lsu_mem_ctrl_pkg::*;
(
   input  logic                  chk_we_i,
   input  logic [2:0]            chk_funct3_i,
   input  logic [1:0]            chk_addr_lo_i,
   output logic                  illegal_o,
   output logic                  misalign_o,
   input  logic [2:0]            funct3_i,
   input  logic [1:0]            addr_lo_i,
   input  logic [DATA_WIDTH-1:0] rdata_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] load_data_o,
   output logic [DATA_WIDTH-1:0] store_data_o
);

   logic [DATA_WIDTH-1:0] lane;

   always_comb begin
      illegal_o  = !f3_legal(chk_we_i, chk_funct3_i);
      misalign_o = 1'b0;
      case (chk_funct3_i[1:0])
         2'b01:   misalign_o = chk_addr_lo_i[0];
         2'b10:   misalign_o = |chk_addr_lo_i;
         default: misalign_o = 1'b0;
      endcase
   end

   // Shift the addressed lane down to bit 0; halfwords are already 2-byte aligned.
   always_comb begin
      lane        = rdata_i >> {addr_lo_i, 3'b000};
      load_data_o = rdata_i;
      case (funct3_i)
         F3_B:    load_data_o = {{24{lane[7]}}, lane[7:0]};
         F3_H:    load_data_o = {{16{lane[15]}}, lane[15:0]};
         F3_BU:   load_data_o = {24'h000000, lane[7:0]};
         F3_HU:   load_data_o = {16'h0000, lane[15:0]};
         default: load_data_o = rdata_i;
      endcase
   end

   always_comb begin
      store_data_o = rdata_i;
      case (funct3_i)
         F3_B:    store_data_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
         F3_H:    store_data_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
         default: store_data_o = wdata_i;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit in front of the word-wide data memory: one request at a time,
// single-cycle read-modify-write for sub-word stores, error response without access.
module lsu_mem_ctrl
   import lsu_mem_ctrl_pkg::*;
#(
   parameter int unsigned MEM_ADDR_W = 10
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [2:0]            req_funct3_i,
   input  logic [31:0]           req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  resp_valid_o,
   output logic [DATA_WIDTH-1:0] resp_rdata_o,
   output logic                  resp_err_o,
   output logic                  mem_we_o,
   output logic [MEM_ADDR_W-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   lsu_state_e            state_q;
   logic                  we_q;
   logic [2:0]            funct3_q;
   logic [1:0]            addr_lo_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  resp_err_q;
   logic [DATA_WIDTH-1:0] resp_rdata_q;
   logic [MEM_ADDR_W-1:0] mem_addr_q;

   logic                  illegal;
   logic                  misalign;
   logic                  out_of_range;
   logic                  req_err;
   logic [DATA_WIDTH-1:0] load_data;
   logic [DATA_WIDTH-1:0] store_data;

   lsu_align u_align (
      .chk_we_i      (req_we_i),
      .chk_funct3_i  (req_funct3_i),
      .chk_addr_lo_i (req_addr_i[1:0]),
      .illegal_o     (illegal),
      .misalign_o    (misalign),
      .funct3_i      (funct3_q),
      .addr_lo_i     (addr_lo_q),
      .rdata_i       (mem_rdata_i),
      .wdata_i       (wdata_q),
      .load_data_o   (load_data),
      .store_data_o  (store_data)
   );

   assign out_of_range = |req_addr_i[31:MEM_ADDR_W];
   assign req_err      = illegal || misalign || out_of_range;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         funct3_q     <= 3'b000;
         addr_lo_q    <= 2'b00;
         wdata_q      <= '0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         mem_addr_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  we_q       <= req_we_i;
                  funct3_q   <= req_funct3_i;
                  addr_lo_q  <= req_addr_i[1:0];
                  wdata_q    <= req_wdata_i;
                  resp_err_q <= req_err;
                  // mem_addr_o only moves for requests that really reach memory.
                  if (!req_err) begin
                     mem_addr_q <= {req_addr_i[MEM_ADDR_W-1:2], 2'b00};
                  end
                  state_q <= req_err ? RESP : ACCESS;
               end
            end
            ACCESS: begin
               resp_rdata_q <= we_q ? '0 : load_data;
               state_q      <= RESP;
            end
            RESP: begin
               resp_err_q   <= 1'b0;
               resp_rdata_q <= '0;
               state_q      <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Write enable is a decode of live state so an asynchronous reset kills it at once.
   assign req_ready_o  = (state_q == IDLE);
   assign resp_valid_o = (state_q == RESP);
   assign mem_we_o     = (state_q == ACCESS) && we_q;
   assign mem_wdata_o  = mem_we_o ? store_data : '0;
   assign mem_addr_o   = mem_addr_q;
   assign resp_err_o   = resp_err_q;
   assign resp_rdata_o = resp_rdata_q;

endmodule
